// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between NREQ requesters, the write arbiter and the Fifo write port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface fifo_write_arbiter_if #(
    parameter int SIZE = 8,
    parameter int NREQ = 4
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SIZE-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic [SIZE-1:0]      fifo_data_in;
    logic                 fifo_valid_write;
    logic                 fifo_full;
    logic                 fifo_almost_full;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_almost_full,
        output req_ready, fifo_data_in, fifo_valid_write, grant_id, busy
    );

    modport master (
        output req_valid, req_data, fifo_full, fifo_almost_full,
        input  req_ready, fifo_data_in, fifo_valid_write, grant_id, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the Fifo write port among NREQ valid/ready requesters,
// granting bounded bursts and throttling on the Fifo full/almost-full flags.
module fifo_write_arbiter #(
    parameter int SIZE  = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                w_clk,
    input  logic                rst,
    fifo_write_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic            wvalid_q, wvalid_d;

    logic            stall;
    logic [GW-1:0]   pick;
    logic            pick_ok;
    logic [NREQ-1:0] ready;
    logic            cur_valid;

    // almost_full leaves room for the single write already registered when stall rises
    assign stall     = bus.fifo_full | bus.fifo_almost_full;
    assign cur_valid = bus.req_valid[grant_q];

    // First valid requester strictly after last_q, wrapping around.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_ok && bus.req_valid[(int'(last_q) + i) % NREQ]) begin
                pick    = GW'((int'(last_q) + i) % NREQ);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        beat_d   = beat_q;
        wdata_d  = wdata_q;
        wvalid_d = 1'b0;
        ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_ok && !stall) begin
                    grant_d = pick;
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end

            S_BURST: begin
                ready[grant_q] = !stall;
                if (cur_valid && !stall) begin
                    wvalid_d = 1'b1;
                    wdata_d  = bus.req_data[int'(grant_q)*SIZE +: SIZE];
                    beat_d   = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        last_d  = grant_q;
                        state_d = S_IDLE;
                    end
                end else if (!cur_valid) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (!cur_valid) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (!stall) begin
                    state_d = S_BURST;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            last_q   <= LAST_REQ;
            beat_q   <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign bus.req_ready        = ready;
    assign bus.fifo_data_in     = wdata_q;
    assign bus.fifo_valid_write = wvalid_q;
    assign bus.grant_id         = grant_q;
    assign bus.busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed requester traffic, expected Fifo
// words queued up front, and a monitor that checks every write the arbiter issues.
module tb_fifo_write_arbiter;
    localparam int SIZE  = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic w_clk = 1'b0;
    logic rst;
    always #5 w_clk = ~w_clk;

    fifo_write_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

    fifo_write_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .w_clk (w_clk),
        .rst   (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_wr  = 0;
    int wr_cyc[$];
    logic [SIZE-1:0] exp_q[$];

    logic [SIZE-1:0] src_mem [NREQ][64];
    int              wr_ix [NREQ];
    int              rd_ix [NREQ];
    logic [NREQ-1:0] hs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic add(input int r, input logic [SIZE-1:0] w);
        src_mem[r][wr_ix[r] % 64] = w;
        wr_ix[r]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++)
            if (rd_ix[i] != wr_ix[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_wr(input string name, input int n);
        int k = 0;
        do begin
            @(posedge w_clk); #2;
            k++;
        end while (n_wr < n && k < 100);
        check(name, 32'(n_wr >= n), 32'd1);
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (bus.busy !== 1'b1 && k < 20) begin
            @(posedge w_clk); #2;
            k++;
        end
        check(name, 32'(bus.busy), 32'd1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((pending() || exp_q.size() != 0 || bus.busy !== 1'b0) && k < 300) begin
            @(posedge w_clk); #2;
            k++;
        end
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    always @(posedge w_clk) begin
        cyc <= cyc + 1;
        hs  <= rst ? '0 : (bus.req_valid & bus.req_ready);
    end

    // Requester models: present the head word of each queue, pop on handshake.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge w_clk);
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] === 1'b1) rd_ix[i]++;
                bus.req_valid[i] = (rd_ix[i] != wr_ix[i]);
                bus.req_data[i*SIZE +: SIZE] = src_mem[i][rd_ix[i] % 64];
            end
        end
    end

    // Monitor: every Fifo write must match the next expected word.
    initial begin
        forever begin
            @(posedge w_clk); #1;
            if (bus.fifo_valid_write === 1'b1) begin
                n_wr++;
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_unexpected: got %0h want none", bus.fifo_data_in);
                end else begin
                    check("write_data", 32'(bus.fifo_data_in), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap_t2 [5] = '{1, 1, 1, 2, 1};

        bus.fifo_full        = 1'b0;
        bus.fifo_almost_full = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid_write", 32'(bus.fifo_valid_write), 32'd0);
        check("rst_busy",        32'(bus.busy),             32'd0);
        check("rst_grant_id",    32'(bus.grant_id),         32'd0);
        check("rst_req_ready",   32'(bus.req_ready),        32'd0);
        repeat (2) @(negedge w_clk);
        #2 rst = 1'b0;

        // 1: reset mid-burst after two beats, then all four valid -> requester 0 first
        for (int s = 1; s <= 4; s++) add(0, 8'(s));
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        wait_wr("t1_two_beats", 2);
        @(negedge w_clk); #2;
        check("t1_ready_before", 32'(bus.req_ready), 32'h1);
        rst = 1'b1;
        #1;
        check("t1_rst_valid_write", 32'(bus.fifo_valid_write), 32'd0);
        check("t1_rst_busy",        32'(bus.busy),             32'd0);
        check("t1_rst_req_ready",   32'(bus.req_ready),        32'd0);
        wr_ix[0] = rd_ix[0];
        check("t1_exp_empty", 32'(exp_q.size()), 32'd0);
        @(negedge w_clk); #2 rst = 1'b0;
        add(0, 8'h05); add(1, 8'h41); add(2, 8'h81); add(3, 8'hC1);
        exp_q.push_back(8'h05); exp_q.push_back(8'h41);
        exp_q.push_back(8'h81); exp_q.push_back(8'hC1);
        wait_busy("t1_busy");
        check("t1_first_grant", 32'(bus.grant_id), 32'd0);
        drain("t1");

        // 2: lone requester 1, six words -> 4-beat burst, one IDLE cycle, then 2 more
        wr_cyc.delete();
        for (int s = 1; s <= 6; s++) begin
            add(1, 8'h50 + 8'(s));
            exp_q.push_back(8'h50 + 8'(s));
        end
        drain("t2");
        check("t2_grant_id", 32'(bus.grant_id), 32'd1);
        check("t2_nwrites", 32'(wr_cyc.size()), 32'd6);
        if (wr_cyc.size() == 6)
            for (int k = 1; k < 6; k++)
                check($sformatf("t2_gap%0d", k), 32'(wr_cyc[k] - wr_cyc[k-1]), 32'(gap_t2[k-1]));

        // 3: all requesters valid from reset -> order 0,1,2,3,0, four writes per five cycles
        @(negedge w_clk); #2 rst = 1'b1;
        @(negedge w_clk); #2 rst = 1'b0;
        wr_cyc.delete();
        for (int s = 1; s <= 8; s++) add(0, 8'h10 + 8'(s));
        for (int s = 1; s <= 4; s++) begin
            add(1, 8'h60 + 8'(s));
            add(2, 8'hA0 + 8'(s));
            add(3, 8'hE0 + 8'(s));
        end
        for (int s = 1; s <= 4; s++) exp_q.push_back(8'h10 + 8'(s));
        for (int s = 1; s <= 4; s++) exp_q.push_back(8'h60 + 8'(s));
        for (int s = 1; s <= 4; s++) exp_q.push_back(8'hA0 + 8'(s));
        for (int s = 1; s <= 4; s++) exp_q.push_back(8'hE0 + 8'(s));
        for (int s = 5; s <= 8; s++) exp_q.push_back(8'h10 + 8'(s));
        drain("t3");
        check("t3_nwrites", 32'(wr_cyc.size()), 32'd20);
        if (wr_cyc.size() == 20)
            for (int k = 1; k < 20; k++)
                check($sformatf("t3_gap%0d", k), 32'(wr_cyc[k] - wr_cyc[k-1]),
                      (k % 4 == 0) ? 32'd2 : 32'd1);
        check("t3_last_grant", 32'(bus.grant_id), 32'd0);

        // 4: almost_full after requester 2's second beat -> HOLD, then beats 3,4 resume
        wr_cyc.delete();
        base = n_wr;
        for (int s = 1; s <= 4; s++) begin
            add(2, 8'h80 + 8'(s));
            exp_q.push_back(8'h80 + 8'(s));
        end
        wait_wr("t4_two_beats", base + 2);
        bus.fifo_almost_full = 1'b1;
        #1;
        check("t4_ready_drop", 32'(bus.req_ready), 32'd0);
        repeat (6) begin
            @(posedge w_clk); #2;
        end
        check("t4_no_writes", 32'(n_wr), 32'(base + 2));
        check("t4_hold_busy", 32'(bus.busy), 32'd1);
        check("t4_hold_grant", 32'(bus.grant_id), 32'd2);
        bus.fifo_almost_full = 1'b0;
        drain("t4");
        check("t4_nwrites", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4)
            check("t4_resume_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd8);

        // 5: fifo_full while idle -> no grant for 10 cycles, grant 0 right after release
        base = n_wr;
        bus.fifo_full = 1'b1;
        add(0, 8'h21);
        exp_q.push_back(8'h21);
        repeat (10) begin
            @(posedge w_clk); #2;
        end
        check("t5_busy",      32'(bus.busy),      32'd0);
        check("t5_no_writes", 32'(n_wr),          32'(base));
        check("t5_ready",     32'(bus.req_ready), 32'd0);
        bus.fifo_full = 1'b0;
        @(posedge w_clk); #2;
        check("t5_grant", 32'(bus.grant_id), 32'd0);
        check("t5_grant_busy", 32'(bus.busy), 32'd1);
        drain("t5");

        // 6: requester 3 releases after two beats -> IDLE, then requester 0 wins over 1
        base = n_wr;
        add(3, 8'hE5); add(3, 8'hE6);
        exp_q.push_back(8'hE5); exp_q.push_back(8'hE6);
        wait_wr("t6_one_beat", base + 1);
        check("t6_grant3", 32'(bus.grant_id), 32'd3);
        add(0, 8'h25); add(1, 8'h65);
        exp_q.push_back(8'h25); exp_q.push_back(8'h65);
        wait_wr("t6_two_beats", base + 2);
        @(posedge w_clk); #2;
        check("t6_release_idle", 32'(bus.busy), 32'd0);
        @(posedge w_clk); #2;
        check("t6_next_grant", 32'(bus.grant_id), 32'd0);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
